// File: rtl/flash_read_ctrl_if.sv
`timescale 1ns/1ps
// Request/stream bundle between a fetch client (master) and flash_read_ctrl (slave).
interface flash_read_ctrl_if;
  logic        req;
  logic [22:0] req_addr;
  logic [3:0]  req_len;
  logic        busy;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        done;

  modport master (
    output req, req_addr, req_len,
    input  busy, rd_data, rd_valid, done
  );

  modport slave (
    input  req, req_addr, req_len,
    output busy, rd_data, rd_valid, done
  );
endinterface

// File: rtl/flash_read_ctrl.sv
`timescale 1ns/1ps
// Read-only initiator for the parallel NOR flash: asynchronous-read cycles with a
// programmable wait count and 1-16 word sequential bursts streamed to one client.
module flash_read_ctrl #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  flash_read_ctrl_if.slave client,
  output logic [22:0]      MemAdr,
  input  logic [15:0]      MemDB,
  output logic             MemOE,
  output logic             MemWR,
  output logic             FlashCS,
  output logic             FlashRp
);

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);

  typedef enum logic [0:0] {IDLE, ACCESS} state_t;

  state_t          state;
  logic [3:0]      rem;
  logic [WW-1:0]   wcnt;

  // CS/OE stay asserted across all words of a burst; each word waits WAIT_CYCLES
  // from the address change before MemDB is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rem             <= '0;
      wcnt            <= '0;
      MemAdr          <= '0;
      MemOE           <= 1'b1;
      MemWR           <= 1'b1;
      FlashCS         <= 1'b1;
      FlashRp         <= 1'b0;
      client.busy     <= 1'b0;
      client.rd_data  <= '0;
      client.rd_valid <= 1'b0;
      client.done     <= 1'b0;
    end else begin
      FlashRp         <= 1'b1;
      MemWR           <= 1'b1;
      client.rd_valid <= 1'b0;
      client.done     <= 1'b0;
      case (state)
        IDLE: begin
          if (client.req) begin
            rem         <= client.req_len;
            MemAdr      <= client.req_addr;
            FlashCS     <= 1'b0;
            MemOE       <= 1'b0;
            client.busy <= 1'b1;
            wcnt        <= WAIT_LAST;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - WW'(1);
          end else begin
            client.rd_data  <= MemDB;
            client.rd_valid <= 1'b1;
            if (rem != '0) begin
              MemAdr <= MemAdr + 23'd1;
              rem    <= rem - 4'd1;
              wcnt   <= WAIT_LAST;
            end else begin
              client.done <= 1'b1;
              client.busy <= 1'b0;
              FlashCS     <= 1'b1;
              MemOE       <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for flash_read_ctrl: two instances (WAIT_CYCLES 5 and 1), each with
// a flash bus model, checked against a word/cycle-level model of accepted bursts.
module tb_flash_read_ctrl;

  localparam int W_A = 5;
  localparam int W_B = 1;
  localparam int NEVER = 32'h7fffffff;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #10 clk = ~clk;

  flash_read_ctrl_if bus_a ();
  flash_read_ctrl_if bus_b ();

  logic [22:0] adr_a, adr_b;
  logic [15:0] db_a, db_b;
  logic        oe_a, wr_a, cs_a, rp_a;
  logic        oe_b, wr_b, cs_b, rp_b;

  // Flash returns the low address bits as data, settling 18 ns after the address moves.
  assign #18 db_a = adr_a[15:0];
  assign #18 db_b = adr_b[15:0];

  flash_read_ctrl #(.WAIT_CYCLES(W_A)) dut_a (
    .clk(clk), .rst(rst_a), .client(bus_a),
    .MemAdr(adr_a), .MemDB(db_a), .MemOE(oe_a), .MemWR(wr_a), .FlashCS(cs_a), .FlashRp(rp_a)
  );

  flash_read_ctrl #(.WAIT_CYCLES(W_B)) dut_b (
    .clk(clk), .rst(rst_b), .client(bus_b),
    .MemAdr(adr_b), .MemDB(db_b), .MemOE(oe_b), .MemWR(wr_b), .FlashCS(cs_b), .FlashRp(rp_b)
  );

  typedef struct {
    int          at_cyc;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic rst_q [2];

  // Model of the burst currently owning each lane, in cycle numbers (edge indices).
  int          wc [2] = '{W_A, W_B};
  int          b_e0 [2] = '{0, 0};
  int          b_n [2] = '{0, 0};
  int          abort_e [2] = '{NEVER, NEVER};
  int          free_e [2] = '{NEVER, NEVER};
  logic [22:0] b_addr [2];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_q[0] <= rst_a;
    rst_q[1] <= rst_b;
  end

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void push_exp(input int ln, input exp_t x);
    if (ln == 0) q_a.push_back(x);
    else q_b.push_back(x);
  endfunction

  // Drives one cycle of request pins (called at a negedge) and, if the model says the
  // lane is idle at the coming edge, records the whole burst it will produce.
  task automatic apply_stimulus(input int ln, input logic req_v, input logic [22:0] a,
                                input logic [3:0] l);
    int e;
    exp_t x;
    logic [22:0] ak;
    e = cyc + 1;
    if (ln == 0) begin
      bus_a.req = req_v; bus_a.req_addr = a; bus_a.req_len = l;
    end else begin
      bus_b.req = req_v; bus_b.req_addr = a; bus_b.req_len = l;
    end
    if (req_v && e >= free_e[ln]) begin
      b_e0[ln]    = e;
      b_n[ln]     = int'(l) + 1;
      b_addr[ln]  = a;
      abort_e[ln] = NEVER;
      free_e[ln]  = e + b_n[ln] * wc[ln] + 1;
      for (int k = 0; k < b_n[ln]; k++) begin
        ak       = a + 23'(k);
        x.at_cyc = e + (k + 1) * wc[ln];
        x.data   = ak[15:0];
        x.last   = (k == b_n[ln] - 1);
        push_exp(ln, x);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int ln, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(ln, 1'b0, '0, '0);
  endtask

  task automatic wait_free(input int ln);
    while (cyc + 1 < free_e[ln]) apply_stimulus(ln, 1'b0, '0, '0);
  endtask

  task automatic reset_checks(input int ln);
    check_output("rst busy",     ln == 0 ? bus_a.busy     : bus_b.busy,     0);
    check_output("rst rd_valid", ln == 0 ? bus_a.rd_valid : bus_b.rd_valid, 0);
    check_output("rst done",     ln == 0 ? bus_a.done     : bus_b.done,     0);
    check_output("rst rd_data",  ln == 0 ? bus_a.rd_data  : bus_b.rd_data,  0);
    check_output("rst MemAdr",   ln == 0 ? adr_a : adr_b, 0);
    check_output("rst MemOE",    ln == 0 ? oe_a  : oe_b,  1);
    check_output("rst FlashCS",  ln == 0 ? cs_a  : cs_b,  1);
    check_output("rst FlashRp",  ln == 0 ? rp_a  : rp_b,  0);
    check_output("rst MemWR",    ln == 0 ? wr_a  : wr_b,  1);
  endtask

  // Pulse reset for one edge; words of the aborted burst at or after that edge vanish.
  task automatic pulse_reset(input int ln);
    int e;
    e = cyc + 1;
    if (ln == 0) begin rst_a = 1'b1; bus_a.req = 1'b0; end
    else begin rst_b = 1'b1; bus_b.req = 1'b0; end
    abort_e[ln] = e;
    free_e[ln]  = e + 1;
    if (ln == 0) while (q_a.size() > 0 && q_a[$].at_cyc >= e) void'(q_a.pop_back());
    else while (q_b.size() > 0 && q_b[$].at_cyc >= e) void'(q_b.pop_back());
    @(negedge clk);
    reset_checks(ln);
    if (ln == 0) rst_a = 1'b0;
    else rst_b = 1'b0;
    @(negedge clk);
    check_output("FlashRp after reset", ln == 0 ? rp_a : rp_b, 1);
  endtask

  task automatic random_phase(input int ln, input int n, input int max_len);
    int gap;
    int hold;
    for (int i = 0; i < n; i++) begin
      gap  = $urandom_range(0, 3);
      hold = $urandom_range(1, 8);
      idle(ln, gap);
      for (int h = 0; h < hold; h++)
        apply_stimulus(ln, 1'b1, 23'($urandom), 4'($urandom_range(0, max_len)));
    end
    apply_stimulus(ln, 1'b0, '0, '0);
    wait_free(ln);
  endtask

  task automatic monitor_lane(input int ln, input logic busy, input logic rd_valid,
                              input logic done, input logic [15:0] data,
                              input logic [22:0] adr, input logic oe, input logic cs,
                              input logic wr, input logic rp);
    logic bexp;
    logic have;
    logic [22:0] ea;
    exp_t f;
    bexp = (cyc >= b_e0[ln]) && (cyc < b_e0[ln] + b_n[ln] * wc[ln]) && (cyc < abort_e[ln]);
    check_output($sformatf("L%0d busy", ln), busy, bexp);
    check_output($sformatf("L%0d FlashCS", ln), cs, !bexp);
    check_output($sformatf("L%0d MemOE", ln), oe, !bexp);
    check_output($sformatf("L%0d MemWR", ln), wr, 1);
    check_output($sformatf("L%0d FlashRp", ln), rp, !rst_q[ln]);
    if (bexp) begin
      ea = b_addr[ln] + 23'((cyc - b_e0[ln]) / wc[ln]);
      check_output($sformatf("L%0d MemAdr", ln), adr, ea);
    end
    have = (ln == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
    if (have) f = (ln == 0) ? q_a[0] : q_b[0];
    if (rd_valid) begin
      if (!have) begin
        check_output($sformatf("L%0d unexpected rd_valid", ln), rd_valid, 0);
      end else begin
        if (ln == 0) void'(q_a.pop_front());
        else void'(q_b.pop_front());
        check_output($sformatf("L%0d rd_valid cycle", ln), cyc, f.at_cyc);
        check_output($sformatf("L%0d rd_data", ln), data, f.data);
        check_output($sformatf("L%0d done", ln), done, f.last);
      end
    end else begin
      check_output($sformatf("L%0d done without rd_valid", ln), done, 0);
      if (have && f.at_cyc <= cyc) begin
        if (ln == 0) void'(q_a.pop_front());
        else void'(q_b.pop_front());
        check_output($sformatf("L%0d missed rd_valid", ln), rd_valid, 1);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      monitor_lane(0, bus_a.busy, bus_a.rd_valid, bus_a.done, bus_a.rd_data, adr_a,
                   oe_a, cs_a, wr_a, rp_a);
      monitor_lane(1, bus_b.busy, bus_b.rd_valid, bus_b.done, bus_b.rd_data, adr_b,
                   oe_b, cs_b, wr_b, rp_b);
    end
  end

  initial begin
    bus_a.req = 1'b0; bus_a.req_addr = '0; bus_a.req_len = '0;
    bus_b.req = 1'b0; bus_b.req_addr = '0; bus_b.req_len = '0;
    repeat (3) @(negedge clk);
    reset_checks(0);
    reset_checks(1);
    rst_a = 1'b0;
    rst_b = 1'b0;
    free_e[0] = cyc + 1;
    free_e[1] = cyc + 1;
    @(negedge clk);

    // Single word, a 4-word burst crossing 0xFFFF, and a burst wrapping the address space.
    apply_stimulus(0, 1'b1, 23'h001234, 4'd0);
    wait_free(0);
    idle(0, 2);
    apply_stimulus(0, 1'b1, 23'h00FFFE, 4'd3);
    wait_free(0);
    idle(0, 1);
    apply_stimulus(0, 1'b1, 23'h7FFFFF, 4'd1);
    wait_free(0);
    idle(0, 3);

    // req held through a burst with the address moving every cycle; only the values
    // present at acceptance matter, and the follow-up starts in the done cycle.
    for (int i = 0; i < 24; i++)
      apply_stimulus(0, 1'b1, 23'h000010 + 23'(i * 'h100), 4'd1);
    apply_stimulus(0, 1'b0, '0, '0);
    wait_free(0);
    idle(0, 2);

    // Reset after the second word of a 16-word burst, then confirm recovery.
    apply_stimulus(0, 1'b1, 23'h000200, 4'd15);
    idle(0, 2 * W_A);
    pulse_reset(0);
    idle(0, 25);
    apply_stimulus(0, 1'b1, 23'h000300, 4'd2);
    wait_free(0);

    random_phase(0, 25, 7);

    // Single-cycle wait: three words on consecutive cycles.
    apply_stimulus(1, 1'b1, 23'h000100, 4'd2);
    wait_free(1);
    idle(1, 2);
    random_phase(1, 40, 15);

    idle(0, 3);
    idle(1, 3);
    check_output("L0 leftover words", q_a.size(), 0);
    check_output("L1 leftover words", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_read_ctrl.md
Name: flash_read_ctrl

Overview:
- Initiator side of the board's parallel NOR flash bus. Drives the pins the top level already exports: FlashCS, MemOE, MemWR, FlashRp and MemAdr. Captures MemDB.
- Serves one internal client, such as the texture/frame fetch feeding VGA, through a request/stream interface.
- Runs asynchronous-read cycles with a programmable wait count. Supports 1–16 word sequential bursts.

Parameters:
WAIT_CYCLES, 5, clk cycles from address/OE valid to data capture (>=1; 5 = 100 ns at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
req  in  1  start request; sampled only in IDLE
req_addr  in  23  first word address (maps to MemAdr[23:1])
req_len  in  4  burst length minus 1 (0 = 1 word, 15 = 16 words)
busy  out  1  burst in progress; req ignored while high
rd_data  out  16  captured word
rd_valid  out  1  one-cycle strobe: rd_data holds a new word
done  out  1  one-cycle strobe coincident with the last rd_valid of a burst
MemAdr  out  23  flash word address, bits [23:1]
MemDB  in  16  flash data bus
MemOE  out  1  output enable, active low
MemWR  out  1  write enable, active low; constant 1 outside reset as well
FlashCS  out  1  chip select, active low
FlashRp  out  1  reset/power-down, active low

Behaviour:
- All outputs are registered.
- Reset values:
  - MemOE=1, MemWR=1, FlashCS=1, FlashRp=0.
  - MemAdr=0, rd_data=0, rd_valid=0, done=0, busy=0.
  - State IDLE, counters 0.
- FlashRp goes to 1 on the first edge with rst=0 and stays 1.
- States:
  - IDLE: FlashCS=MemOE=1. If req=1, then at the edge: latch req_len into the remaining-word counter rem; MemAdr<=req_addr; FlashCS<=0; MemOE<=0; busy<=1; wcnt<=WAIT_CYCLES-1; go to ACCESS.
  - ACCESS: address held stable. If wcnt!=0, decrement it. If wcnt==0, then at the edge:
    - rd_data<=MemDB and rd_valid<=1.
    - If rem!=0: MemAdr<=MemAdr+1 (23-bit, wraps 0x7FFFFF→0x000000), rem<=rem-1, wcnt<=WAIT_CYCLES-1, stay in ACCESS. FlashCS and MemOE stay low between words.
    - If rem==0: done<=1, busy<=0, FlashCS<=1, MemOE<=1, go to IDLE. MemAdr keeps its last value.
- Timing (req sampled at edge E0):
  - Address is valid in the cycles after E0.
  - Capture happens at edge E0+WAIT_CYCLES.
  - rd_valid is high in the cycle after that edge.
  - Word k captures at E0+(k+1)*WAIT_CYCLES.
  - Burst of N words: busy high for N*WAIT_CYCLES cycles.
- rd_valid and done are single-cycle pulses. The client has no backpressure and must accept every rd_valid.
- req while busy=1 is ignored, not queued. req in the same cycle as the final rd_valid/done is accepted, since the state is IDLE by then. Back-to-back bursts therefore have no dead cycle.
- req_addr and req_len are sampled only at acceptance; later changes have no effect.
- rst mid-burst: the next edge forces all reset values. No rd_valid or done is produced for the aborted burst, and FlashCS/MemOE deassert at that edge.
- MemWR is never driven low: this block is read-only.

Test Plan:
- Bus model: MemDB = MemAdr[16:1], updated 18 ns after any MemAdr change. Clock 20 ns.
- Single word, WAIT_CYCLES=5: req_addr=0x001234, req_len=0 -> FlashCS/MemOE low 5 cycles; rd_valid and done in cycle 6 after acceptance; rd_data=0x1234; busy low in that cycle.
- Burst: req_addr=0x00FFFE, req_len=3 -> rd_data 0xFFFE, 0xFFFF, 0x0000, 0x0001; rd_valid spaced 5 cycles apart; done only with the 4th; CS/OE continuously low for 20 cycles.
- Wrap: req_addr=0x7FFFFF, req_len=1 -> MemAdr 0x7FFFFF then 0x000000; rd_data 0xFFFF then 0x0000.
- Busy and back-to-back: req held high through a burst from 0x000010 with req_len=1 -> second req ignored until the done cycle; next burst accepted in the done cycle with no idle gap.
- Reset mid-burst: rst pulsed after word 2 of a 16-word burst -> next cycle MemOE=FlashCS=1, FlashRp=0, busy=0; no further rd_valid or done; FlashRp=1 one cycle after rst drops.
- WAIT_CYCLES=1: req_len=2 from 0x000100 -> rd_valid on 3 consecutive cycles with 0x0100, 0x0101, 0x0102; MemWR=1 throughout all tests.
